mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit for the multicycle MIPS datapath. It computes 32x32 signed MULT and DIV over multiple cycles and holds the results in its own Hi and Lo registers. Those registers feed the Hi and Lo inputs of the SrcOut result mux directly, which serves MFHI/MFLO. The control unit starts an operation, stalls on Busy, and reacts to DivZero as an exception.

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Sequential 32x32 signed multiply (radix-2 Booth) and divide (restoring) unit.
// Hi/Lo are architectural registers read directly by MFHI/MFLO.
module mult_div_unit #(
    parameter int N_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MultStart,
    input  logic        DivStart,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero
);

    localparam int CW = $clog2(N_ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [64:0]   work;
    logic [31:0]   m;
    logic          neg_q, neg_r, dz;

    logic          last;
    logic          b_zero;
    logic [31:0]   abs_a, abs_b;
    logic [32:0]   acc_ext, m_ext, sum;
    logic [64:0]   booth_next;
    logic [32:0]   trial;
    logic          ge;
    logic [31:0]   rem_n;
    logic [64:0]   div_next;
    logic [31:0]   q_fix, r_fix;

    always_comb begin
        last   = (cnt == CW'(N_ITER - 1));
        b_zero = (B == '0);
        abs_a  = A[31] ? 32'(-A) : A;
        abs_b  = B[31] ? 32'(-B) : B;
    end

    // Booth step: the sum is formed one bit wider so that subtracting the
    // most negative multiplicand cannot lose its sign before the shift.
    always_comb begin
        acc_ext = {work[64], work[64:33]};
        m_ext   = {m[31], m};
        case (work[1:0])
            2'b01:   sum = acc_ext + m_ext;
            2'b10:   sum = acc_ext - m_ext;
            default: sum = acc_ext;
        endcase
        booth_next = {sum, work[32:2], work[1]};
    end

    // Restoring step on magnitudes: work holds {remainder, dividend/quotient, 0}.
    always_comb begin
        trial    = {work[64:33], work[32]};
        ge       = (trial >= {1'b0, m});
        rem_n    = ge ? (trial[31:0] - m) : trial[31:0];
        div_next = {rem_n, work[31:1], ge, 1'b0};
        q_fix    = neg_q ? 32'(-div_next[32:1])  : div_next[32:1];
        r_fix    = neg_r ? 32'(-div_next[64:33]) : div_next[64:33];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (MultStart) begin
                    state_nxt = S_MULT;
                end else if (DivStart) begin
                    state_nxt = b_zero ? S_DONE : S_DIV;
                end
            end
            S_MULT, S_DIV: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state == S_MULT) || (state == S_DIV);
        Done    = (state == S_DONE);
        DivZero = (state == S_DONE) && dz;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            work  <= '0;
            m     <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
        end else begin
            dz <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (MultStart) begin
                        m    <= A;
                        work <= {32'b0, B, 1'b0};
                    end else if (DivStart) begin
                        if (b_zero) begin
                            dz <= 1'b1;
                        end else begin
                            m     <= abs_b;
                            work  <= {32'b0, abs_a, 1'b0};
                            neg_q <= A[31] ^ B[31];
                            neg_r <= A[31];
                        end
                    end
                end
                S_MULT: begin
                    work <= booth_next;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        Hi <= booth_next[64:33];
                        Lo <= booth_next[32:1];
                    end
                end
                S_DIV: begin
                    work <= div_next;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        Hi <= r_fix;
                        Lo <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected Hi/Lo/DivZero,
// a monitor pops on every Done and also polices Hi/Lo stability.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MultStart, DivStart;
    logic [31:0] A, B;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, DivZero;

    mult_div_unit #(.N_ITER(32)) dut (
        .clk(clk), .reset(reset), .MultStart(MultStart), .DivStart(DivStart),
        .A(A), .B(B), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    bit          mon_en = 0;
    logic [31:0] prev_hi, prev_lo;
    logic        prev_done = 1'b0;
    bit          rst_edge_low = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain signed 64-bit arithmetic; divide truncates toward zero
    // and % takes the dividend's sign, matching MIPS DIV.
    function automatic void push_expect(input bit mul, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        exp_t   e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dz = 1'b0;
        if (mul) begin
            p = sa * sb;
            model_hi = p[63:32];
            model_lo = p[31:0];
        end else if (b == 32'd0) begin
            e.dz = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            model_hi = r[31:0];
            model_lo = q[31:0];
        end
        e.hi = model_hi;
        e.lo = model_lo;
        exp_q.push_back(e);
    endfunction

    always @(posedge clk) rst_edge_low = (reset == 1'b0);

    always @(negedge clk) begin
        if (mon_en) begin
            if (Done) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: Done=1 with no operation outstanding");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hi", 64'(Hi), 64'(e.hi));
                    check("lo", 64'(Lo), 64'(e.lo));
                    check("divzero", 64'(DivZero), 64'(e.dz));
                end
                if (prev_done) begin
                    n_total++;
                    $display("FAIL done_width: Done high for two consecutive cycles");
                end
            end else if (DivZero) begin
                n_total++;
                $display("FAIL divzero_alone: DivZero=1 while Done=0");
            end
            if (Hi !== prev_hi || Lo !== prev_lo) begin
                n_total++;
                if ((Done && !DivZero) || rst_edge_low) n_pass++;
                else $display("FAIL hilo_hold: Hi/Lo changed to %0h/%0h from %0h/%0h", Hi, Lo, prev_hi, prev_lo);
            end
        end
        prev_hi   = Hi;
        prev_lo   = Lo;
        prev_done = Done;
    end

    task automatic run_op(input bit mul, input bit div, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        int busy_cyc;
        int lat;
        bit seen;
        bit is_dz;
        is_dz = !mul && div && (b == 32'd0);
        @(negedge clk);
        A = a; B = b; MultStart = mul; DivStart = div;
        @(posedge clk);
        #1;
        MultStart = 1'b0; DivStart = 1'b0;
        A = $urandom; B = $urandom;
        push_expect(mul, a, b);
        busy_cyc = 0; seen = 0; lat = -1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (Busy) busy_cyc++;
            if (Done) begin seen = 1; lat = c; end
            if (poke && c == 5) begin
                DivStart = 1'b1; MultStart = 1'b1; A = $urandom; B = $urandom;
            end else if (poke && c == 6) begin
                DivStart = 1'b0; MultStart = 1'b0;
            end
        end
        check("done_seen", 64'(seen), 64'(1));
        check("done_latency", 64'(lat), is_dz ? 64'(0) : 64'(32));
        check("busy_cycles", 64'(busy_cyc), is_dz ? 64'(0) : 64'(32));
        @(negedge clk);
        check("done_single", 64'(Done), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        reset = 1'b0; MultStart = 1'b0; DivStart = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", 64'(Hi), 64'(0));
        check("rst_lo", 64'(Lo), 64'(0));
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_done", 64'(Done), 64'(0));
        check("rst_divzero", 64'(DivZero), 64'(0));
        reset = 1'b1;
        mon_en = 1;

        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_7_m3_hi", 64'(Hi), 64'h0000_0000_FFFF_FFFF);
        check("mul_7_m3_lo", 64'(Lo), 64'h0000_0000_FFFF_FFEB);
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        check("mul_min_min_hi", 64'(Hi), 64'h4000_0000);
        check("mul_min_min_lo", 64'(Lo), 64'h0);
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul_m1_m1_hi", 64'(Hi), 64'h0);
        check("mul_m1_m1_lo", 64'(Lo), 64'h1);

        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_2_lo", 64'(Lo), 64'hFFFF_FFFD);
        check("div_m7_2_hi", 64'(Hi), 64'hFFFF_FFFF);
        run_op(0, 1, 32'd100, 32'hFFFF_FFF9, 0);
        check("div_100_m7_lo", 64'(Lo), 64'hFFFF_FFF2);
        check("div_100_m7_hi", 64'(Hi), 64'h2);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_min_m1_lo", 64'(Lo), 64'h8000_0000);
        check("div_min_m1_hi", 64'(Hi), 64'h0);

        // 0x66666666 * 0x2AAAAAAB = 0x11111111_22222222
        run_op(1, 0, 32'h6666_6666, 32'h2AAA_AAAB, 0);
        check("preload_hi", 64'(Hi), 64'h1111_1111);
        check("preload_lo", 64'(Lo), 64'h2222_2222);
        run_op(0, 1, 32'd55, 32'd0, 0);
        check("dz_hi_kept", 64'(Hi), 64'h1111_1111);
        check("dz_lo_kept", 64'(Lo), 64'h2222_2222);

        // Abort a multiply with reset ten cycles in; nothing is queued for it.
        @(negedge clk);
        A = 32'd12345; B = 32'd678; MultStart = 1'b1;
        @(posedge clk);
        #1 MultStart = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_hi", 64'(Hi), 64'h0);
        check("abort_lo", 64'(Lo), 64'h0);
        check("abort_busy", 64'(Busy), 64'h0);
        check("abort_done", 64'(Done), 64'h0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'(0));
        run_op(0, 1, 32'd9, 32'd4, 0);
        check("div_9_4_lo", 64'(Lo), 64'h2);
        check("div_9_4_hi", 64'(Hi), 64'h1);

        run_op(1, 1, 32'hFFFF_FFF0, 32'd3, 0);
        check("both_start_lo", 64'(Lo), 64'hFFFF_FFD0);
        run_op(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        run_op(0, 1, 32'hDEAD_BEEF, 32'h0000_1234, 1);

        for (int i = 0; i < 1000; i++) begin
            int sel;
            logic [31:0] ra, rb;
            sel = $urandom_range(0, 9);
            ra = pick();
            rb = pick();
            if (sel < 5)       run_op(1, 0, ra, rb, 0);
            else if (sel < 9)  run_op(0, 1, ra, rb, 0);
            else               run_op(0, 1, ra, 32'd0, 0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
